// File: rtl/debug_scan_sequencer.sv
// debug_scan_sequencer
// Frame-based readout of the SNN debug state. A start request snapshots every
// membrane potential and both spike layers in one cycle. The snapshot is then
// streamed as 8-bit words over a valid/ready port.
//
// Frame layout (idx : word):
//   0 .. NUM_NEURONS-1 : potential of neuron idx, zero-extended to 8 bits
//   NUM_NEURONS        : layer-1 spike vector
//   NUM_NEURONS+1      : layer-2 spike vector
//   NUM_NEURONS+2      : XOR of all preceding words (only with DEBUG_SCAN_CHECKSUM_EN)
//
// Optional feature macro: DEBUG_SCAN_CHECKSUM_EN appends the checksum word.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; the stream port is quiet
// S_CAPTURE | one cycle; the snapshot registers load on the exit edge
// S_SEND    | presents word[idx]; idx advances on each accepted word
// S_DONE    | one cycle; frame_done pulses, then back to idle

module debug_scan_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int POT_BITS    = 6,
    parameter int SPK_BITS    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [NUM_NEURONS*POT_BITS-1:0] membrane_potentials,
    input  logic [SPK_BITS-1:0]             output_spikes_layer1,
    input  logic [SPK_BITS-1:0]             output_spikes_layer2,
    output logic [7:0]                      out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_last,
    output logic                            busy,
    output logic                            frame_done,
    output logic [7:0]                      drop_count
);

`ifdef DEBUG_SCAN_CHECKSUM_EN
    localparam int FRAME_LEN = NUM_NEURONS + 3;
`else
    localparam int FRAME_LEN = NUM_NEURONS + 2;
`endif
    localparam int IDX_W = $clog2(FRAME_LEN);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] L1_IDX   = IDX_W'(NUM_NEURONS);
    localparam logic [IDX_W-1:0] L2_IDX   = IDX_W'(NUM_NEURONS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_SEND    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 snap_load;
    logic [POT_BITS-1:0]  snap_pot_q [NUM_NEURONS];
    logic [SPK_BITS-1:0]  snap_l1_q;
    logic [SPK_BITS-1:0]  snap_l2_q;
    logic [7:0]           drop_q, drop_d;
    logic [7:0]           word;

    // State and word index registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Snapshot registers: loaded once per frame, frozen while streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                snap_pot_q[i] <= '0;
            end
            snap_l1_q <= '0;
            snap_l2_q <= '0;
        end else if (snap_load) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                snap_pot_q[i] <= membrane_potentials[i*POT_BITS +: POT_BITS];
            end
            snap_l1_q <= output_spikes_layer1;
            snap_l2_q <= output_spikes_layer2;
        end
    end

`ifdef DEBUG_SCAN_CHECKSUM_EN
    logic [7:0] csum;

    // Checksum over the snapshot; stable for the whole frame since the snapshot is.
    always_comb begin
        csum = 8'(snap_l1_q) ^ 8'(snap_l2_q);
        for (int i = 0; i < NUM_NEURONS; i++) begin
            csum = csum ^ 8'(snap_pot_q[i]);
        end
    end
`endif

    // Frame word selected by the current index.
    always_comb begin
        word = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                word = 8'(snap_pot_q[i]);
            end
        end
        if (idx_q == L1_IDX) begin
            word = 8'(snap_l1_q);
        end
        if (idx_q == L2_IDX) begin
            word = 8'(snap_l2_q);
        end
`ifdef DEBUG_SCAN_CHECKSUM_EN
        if (idx_q == LAST_IDX) begin
            word = csum;
        end
`endif
    end

    // Next-state logic and stream outputs.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_load  = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        busy       = 1'b1;
        frame_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy  = 1'b0;
                idx_d = '0;
                if (start) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                snap_load = 1'b1;
                idx_d     = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                out_data  = word;
                out_last  = (idx_q == LAST_IDX);
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Saturating count of start requests that arrive while a frame is in flight.
    always_comb begin
        drop_d = drop_q;
        if (start && (state_q != S_IDLE) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

endmodule

// File: tb/tb_debug_scan_sequencer.sv
// Testbench for debug_scan_sequencer: randomized frames checked against a
// frame model built directly from the word layout.
// Build with DEBUG_SCAN_CHECKSUM_EN to exercise the checksum word.

module tb_debug_scan_sequencer;

    localparam int NN = 16;
    localparam int PB = 6;
    localparam int SB = 8;
`ifdef DEBUG_SCAN_CHECKSUM_EN
    localparam int FL = NN + 3;
`else
    localparam int FL = NN + 2;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [NN*PB-1:0]  pots;
    logic [SB-1:0]     l1;
    logic [SB-1:0]     l2;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              frame_done;
    logic [7:0]        drop_count;

    debug_scan_sequencer #(
        .NUM_NEURONS(NN),
        .POT_BITS   (PB),
        .SPK_BITS   (SB)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .membrane_potentials (pots),
        .output_spikes_layer1(l1),
        .output_spikes_layer2(l2),
        .out_data            (out_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_last            (out_last),
        .busy                (busy),
        .frame_done          (frame_done),
        .drop_count          (drop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [7:0] exp_q[$];
    int         exp_drop;

    // Expected frame from the current input values, straight from the word layout.
    function automatic void build_frame();
        logic [7:0] x;
        exp_q.delete();
        for (int i = 0; i < NN; i++) begin
            exp_q.push_back(8'(pots[i*PB +: PB]));
        end
        exp_q.push_back(8'(l1));
        exp_q.push_back(8'(l2));
`ifdef DEBUG_SCAN_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
`endif
    endfunction

    function automatic void note_drop();
        if (exp_drop < 255) exp_drop++;
    endfunction

    task automatic randomize_inputs();
        for (int i = 0; i < NN; i++) begin
            pots[i*PB +: PB] = PB'($urandom);
        end
        l1 = SB'($urandom);
        l2 = SB'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Free-running event counters sampled mid-cycle.
    int busy_cyc = 0;
    int fd_cyc   = 0;
    always @(negedge clk) begin
        if (busy) busy_cyc++;
        if (frame_done) fd_cyc++;
    end

    // Pulse start from idle; returns in the first streaming cycle.
    task automatic start_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        check("cap_busy", busy, 1);
        check("cap_valid", out_valid, 0);
        step();
        check("first_valid", out_valid, 1);
    endtask

    // Consume words. mode: 0 ready=1, 1 ready pattern 1,0,0,1, 2 random ready.
    // pulses: 0 none, 1 three directed starts, 2 random starts.
    task automatic recv(input int mode, input int stop_at, input int pulses);
        int         got;
        int         it;
        logic       stalled;
        logic [7:0] hd;
        logic       hl;
        got     = 0;
        it      = 0;
        stalled = 1'b0;
        hd      = '0;
        hl      = 1'b0;
        while (got < stop_at && it < 2000) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((it % 4) == 0) || ((it % 4) == 3);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (pulses == 1)      start = (it == 2) || (it == 4) || (it == 6);
            else if (pulses == 2) start = ($urandom_range(0, 3) == 0);
            else                  start = 1'b0;
            if (start) note_drop();
            @(negedge clk);
            if (!out_valid) begin
                check("valid_held", out_valid, 1);
                break;
            end
            if (stalled) begin
                check("hold_data", out_data, hd);
                check("hold_last", out_last, hl);
            end
            check("last", out_last, (got == FL - 1));
            if (out_ready) begin
                check("word", out_data, exp_q[got]);
                got++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                hd      = out_data;
                hl      = out_last;
            end
            step();
            it++;
        end
        start = 1'b0;
        if (got < stop_at) check("recv_timeout", got, stop_at);
    endtask

    task automatic finish_frame();
        check("done_pulse", frame_done, 1);
        check("done_valid", out_valid, 0);
        step();
        check("idle_busy", busy, 0);
        check("done_clear", frame_done, 0);
        check("drop", drop_count, exp_drop);
    endtask

    int b0;
    int f0;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        pots      = '0;
        l1        = '0;
        l2        = '0;
        exp_drop  = 0;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_data", out_data, 0);
        check("rst_drop", drop_count, 0);
        rst = 1'b0;
        step();

        // Basic frame with known contents and full-rate consumer.
        for (int i = 0; i < NN; i++) pots[i*PB +: PB] = PB'(i + 1);
        l1 = 8'hA5;
        l2 = 8'h3C;
        build_frame();
        b0 = busy_cyc;
        f0 = fd_cyc;
        start_frame();
        recv(0, FL, 0);
        finish_frame();
        check("frame_cycles", busy_cyc - b0, FL + 2);
        check("fd_count", fd_cyc - f0, 1);

        // Immediate restart under backpressure.
        randomize_inputs();
        build_frame();
        start_frame();
        recv(1, FL, 0);
        finish_frame();

        // Inputs change right after capture; the stream must not see it.
        randomize_inputs();
        build_frame();
        start_frame();
        pots = '1;
        l1   = '1;
        l2   = '1;
        recv(2, FL, 0);
        finish_frame();

        // Three stray starts mid-frame: counted, no second frame.
        randomize_inputs();
        build_frame();
        start_frame();
        recv(0, FL, 1);
        finish_frame();
        for (int k = 0; k < 5; k++) begin
            step();
            check("no_restart", busy, 0);
        end

        // Random frames with random backpressure and random stray starts.
        for (int n = 0; n < 6; n++) begin
            randomize_inputs();
            build_frame();
            f0 = fd_cyc;
            start_frame();
            recv(2, FL, 2);
            finish_frame();
            check("rand_fd_count", fd_cyc - f0, 1);
        end

        // Start held high with a stalled consumer saturates the drop counter.
        randomize_inputs();
        build_frame();
        out_ready = 1'b0;
        start     = 1'b1;
        step();
        for (int k = 0; k < 300; k++) begin
            step();
            note_drop();
        end
        start = 1'b0;
        check("sat_drop", drop_count, exp_drop);
        check("sat_valid", out_valid, 1);
        check("sat_word0", out_data, exp_q[0]);
        rst = 1'b1;
        step();
        rst      = 1'b0;
        exp_drop = 0;
        check("sat_rst_drop", drop_count, 0);
        check("sat_rst_busy", busy, 0);
        step();

        // Reset in the middle of a frame, then a clean frame from word 0.
        randomize_inputs();
        build_frame();
        start_frame();
        recv(0, 5, 0);
        check("mid_word5", out_data, exp_q[5]);
        f0  = fd_cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop", drop_count, 0);
        check("mid_rst_done", frame_done, 0);
        step();
        step();
        check("mid_rst_no_fd", fd_cyc - f0, 0);
        randomize_inputs();
        build_frame();
        start_frame();
        recv(2, FL, 0);
        finish_frame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
